// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell, registered carry,
// LSB-first, WIDTH cycles per operation with start/busy/done handshake.
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   start          request; accepted in IDLE or DONE only
//   sub            0: a + b + cin, 1: a - b (cin ignored)
//   a, b, cin      operands, captured on the accepting edge
//   busy           high while bits are processed
//   done           one-cycle pulse, result valid
//   sum            result (partial contents while busy)
//   cout           carry out of MSB (subtract: 1 = no borrow)
//   overflow       signed overflow
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic fa_bit;
  logic fa_carry;
  logic last;

  assign fa_bit   = opa_q[0] ^ opb_q[0] ^ carry_q;
  assign fa_carry = (opa_q[0] & opb_q[0])
                  | (opa_q[0] & carry_q)
                  | (opb_q[0] & carry_q);
  assign last     = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Subtraction is a + ~b + 1: invert b and force carry-in.
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        sum_d   = {fa_bit, sum_q[WIDTH-1:1]};
        carry_d = fa_carry;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last) begin
          // carry_q is the carry into the MSB here.
          cout_d  = fa_carry;
          ovf_d   = carry_q ^ fa_carry;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed handshake scenarios at WIDTH=8,
// random ops at WIDTH=8, exhaustive WIDTH=4, against an arithmetic model.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;
  logic       start4 = 1'b0, sub4 = 1'b0, cin4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, cout4, ovf4;
  logic [3:0] sum4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8),
    .a(a8), .b(b8), .cin(cin8), .busy(busy8), .done(done8),
    .sum(sum8), .cout(cout8), .overflow(ovf8)
  );

  serial_adder #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub4),
    .a(a4), .b(b4), .cin(cin4), .busy(busy4), .done(done4),
    .sum(sum4), .cout(cout4), .overflow(ovf4)
  );

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic void model(input int w, input longint a,
                                input longint b, input bit ci,
                                input bit sb, output longint s,
                                output bit co, output bit ov);
    longint m, half, sa, sbv, r, sr;
    m    = longint'(1) << w;
    half = m / 2;
    sa   = (a >= half) ? a - m : a;
    sbv  = (b >= half) ? b - m : b;
    if (sb) begin
      r  = a - b;
      co = (a >= b);
      sr = sa - sbv;
    end else begin
      r  = a + b + longint'(ci);
      co = (r >= m);
      sr = sa + sbv + longint'(ci);
    end
    s  = ((r % m) + m) % m;
    ov = (sr > half - 1) || (sr < -half);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b,
                        input bit ci, input bit sb);
    a8 = a; b8 = b; cin8 = ci; sub8 = sb; start8 = 1'b1;
    tick();
    start8 = 1'b0;
  endtask

  // Called just after the accepting edge; lat = edges until done.
  task automatic wait8(output int lat, output int bc, output bit both);
    lat = -1; bc = 0; both = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) tick();
      if (busy8 && done8) both = 1'b1;
      if (busy8) bc++;
      if (done8) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    tests++;
    if ({busy8, done8, sum8, cout8, ovf8} !== 12'h0) begin
      fails++;
      $display("FAIL reset8: got busy=%b done=%b sum=%h cout=%b ovf=%b want 0",
               busy8, done8, sum8, cout8, ovf8);
    end
    tests++;
    if ({busy4, done4, sum4, cout4, ovf4} !== 8'h0) begin
      fails++;
      $display("FAIL reset4: got busy=%b done=%b sum=%h want 0",
               busy4, done4, sum4);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    logic [7:0] ta [5] = '{8'h35, 8'hFF, 8'h7F, 8'h05, 8'h80};
    logic [7:0] tb [5] = '{8'h4A, 8'h01, 8'h01, 8'h07, 8'h01};
    bit         tc [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    bit         ts [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] es [5] = '{8'h7F, 8'h01, 8'h80, 8'hFE, 8'h7F};
    bit         ec [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    bit         eo [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int lat, bc;
    bit both;
    for (int i = 0; i < 5; i++) begin
      issue8(ta[i], tb[i], tc[i], ts[i]);
      wait8(lat, bc, both);
      tests++;
      if (lat !== 8 || bc !== 8 || both) begin
        fails++;
        $display("FAIL dir%0d timing: lat=%0d busy=%0d both=%b want 8 8 0",
                 i, lat, bc, both);
      end
      tests++;
      if (sum8 !== es[i] || cout8 !== ec[i] || ovf8 !== eo[i]) begin
        fails++;
        $display("FAIL dir%0d result: got %h/%b/%b want %h/%b/%b",
                 i, sum8, cout8, ovf8, es[i], ec[i], eo[i]);
      end
      tick();
      tests++;
      if (done8 !== 1'b0) begin
        fails++;
        $display("FAIL dir%0d pulse: done=%b want 0", i, done8);
      end
    end
  endtask

  task automatic test_start_ignored();
    int lat = -1;
    issue8(8'h12, 8'h34, 1'b0, 1'b0);
    for (int c = 0; c < 20; c++) begin
      if (c > 0) tick();
      if (done8) begin
        lat = c;
        break;
      end
      if (c == 2) begin
        a8 = 8'hAA; b8 = 8'hCC; sub8 = 1'b1; start8 = 1'b1;
      end
      if (c == 3) start8 = 1'b0;
    end
    tests++;
    if (lat !== 8 || sum8 !== 8'h46 || cout8 !== 1'b0) begin
      fails++;
      $display("FAIL start_ignored: lat=%0d sum=%h cout=%b want 8 46 0",
               lat, sum8, cout8);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    bit both;
    issue8(8'h01, 8'h02, 1'b0, 1'b0);
    wait8(lat, bc, both);
    tests++;
    if (lat !== 8 || sum8 !== 8'h03) begin
      fails++;
      $display("FAIL b2b first: lat=%0d sum=%h want 8 03", lat, sum8);
    end
    issue8(8'h10, 8'h20, 1'b0, 1'b0);
    tests++;
    if (busy8 !== 1'b1 || done8 !== 1'b0) begin
      fails++;
      $display("FAIL b2b gap: busy=%b done=%b want 1 0", busy8, done8);
    end
    wait8(lat, bc, both);
    tests++;
    if (lat !== 8 || bc !== 8 || sum8 !== 8'h30 || both) begin
      fails++;
      $display("FAIL b2b second: lat=%0d busy=%0d sum=%h want 8 8 30",
               lat, bc, sum8);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int lat, bc, seen;
    bit both;
    issue8(8'hFF, 8'hFF, 1'b1, 1'b0);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if ({busy8, done8, sum8, cout8, ovf8} !== 12'h0) begin
      fails++;
      $display("FAIL reset_mid: busy=%b done=%b sum=%h cout=%b ovf=%b want 0",
               busy8, done8, sum8, cout8, ovf8);
    end
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (done8 || busy8) seen++;
      tick();
    end
    tests++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL reset_mid ghost: %0d active cycles want 0", seen);
    end
    issue8(8'h01, 8'h01, 1'b0, 1'b0);
    wait8(lat, bc, both);
    tests++;
    if (lat !== 8 || sum8 !== 8'h02) begin
      fails++;
      $display("FAIL reset_mid after: lat=%0d sum=%h want 8 02", lat, sum8);
    end
    tick();
  endtask

  task automatic test_random8();
    int lat, bc;
    bit both;
    longint es;
    bit ec, eo;
    logic [7:0] ra, rb;
    bit rc, rs;
    for (int i = 0; i < 100; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      rc = 1'($urandom); rs = 1'($urandom);
      model(8, longint'(ra), longint'(rb), rc, rs, es, ec, eo);
      issue8(ra, rb, rc, rs);
      // Operands may change freely while running.
      a8 = 8'($urandom); b8 = 8'($urandom);
      sub8 = 1'($urandom); cin8 = 1'($urandom);
      wait8(lat, bc, both);
      tests++;
      if (lat !== 8 || both || sum8 !== 8'(es) ||
          cout8 !== ec || ovf8 !== eo) begin
        fails++;
        $display("FAIL rand8 %h%s%h c%b: lat=%0d got %h/%b/%b want %h/%b/%b",
                 ra, rs ? "-" : "+", rb, rc, lat,
                 sum8, cout8, ovf8, 8'(es), ec, eo);
      end
      if ($urandom_range(1, 0) == 1) tick();
    end
  endtask

  task automatic test_exhaustive4();
    int lat;
    longint es;
    bit ec, eo;
    for (int s = 0; s < 2; s++)
      for (int ci = 0; ci < 2; ci++)
        for (int a = 0; a < 16; a++)
          for (int b = 0; b < 16; b++) begin
            model(4, longint'(a), longint'(b), 1'(ci), 1'(s), es, ec, eo);
            a4 = 4'(a); b4 = 4'(b); cin4 = 1'(ci); sub4 = 1'(s);
            start4 = 1'b1;
            tick();
            start4 = 1'b0;
            lat = -1;
            for (int c = 0; c < 12; c++) begin
              if (c > 0) tick();
              if (done4) begin
                lat = c;
                break;
              end
            end
            tests++;
            if (lat !== 4 || sum4 !== 4'(es) ||
                cout4 !== ec || ovf4 !== eo) begin
              fails++;
              $display("FAIL ex4 %0d%s%0d c%0d: lat=%0d got %h/%b/%b want %h/%b/%b",
                       a, s ? "-" : "+", b, ci, lat,
                       sum4, cout4, ovf4, 4'(es), ec, eo);
            end
          end
    tick();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_random8();
    test_exhaustive4();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
